pwm_seq_ctrl: RTL and testbench

//  Multi-channel PWM controller behind an Avalon-MM slave. One shared period counter.
//  Per-channel duty registers, double-buffered and applied atomically at period wrap.

---
 rtl/pwm_seq_pkg.sv | 25 ++
 rtl/pwm_ch_cmp.sv | 36 +++
 rtl/pwm_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_pwm_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared register map, control/status bit positions and the CTRL write layout
// for the multi-channel PWM sequencer.
package pwm_seq_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_PERIOD = 4'd1;
    localparam logic [3:0] ADDR_STATUS = 4'd2;
    localparam logic [3:0] ADDR_DUTY0  = 4'd4;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_UPD_BIT  = 1;
    localparam int STAT_PEND_BIT = 0;
    localparam int STAT_RUN_BIT  = 1;

    // Field order follows the CTRL bit positions: upd is bit 1, en is bit 0.
    typedef struct packed {
        logic upd;
        logic en;
    } ctrl_t;

    function automatic logic [3:0] duty_addr(input int ch);
        return 4'(int'(ADDR_DUTY0) + ch);
    endfunction

endpackage

// File: rtl/pwm_ch_cmp.sv
// One PWM channel: active duty register, unsigned compare against the shared
// counter and a registered, glitch-free output.
module pwm_ch_cmp
    import pwm_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_duty_sh,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_pwm
);

    logic [CNT_W-1:0] r_duty_act;
    logic             r_pwm;

    // The compare uses the duty value held before any load on this same edge,
    // so the wrap cycle is still judged against the outgoing period's duty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty_act <= '0;
            r_pwm      <= 1'b0;
        end else begin
            if (i_load) begin
                r_duty_act <= i_duty_sh;
            end
            r_pwm <= i_en && (i_cnt < r_duty_act);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_seq_ctrl.sv
// Avalon-MM PWM controller: bus decode, shadow registers, update-pending flag
// and the shared period counter feeding N_CH compare channels.
module pwm_seq_ctrl
    import pwm_seq_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_TOP = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      avs_s0_address,
    input  logic            avs_s0_read,
    input  logic            avs_s0_write,
    output logic [31:0]     avs_s0_readdata,
    input  logic [31:0]     avs_s0_writedata,
    output logic [N_CH-1:0] PWM_out,
    output logic            period_tick
);

    logic             r_en;
    logic             r_pending;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_top_sh;
    logic [CNT_W-1:0] r_top_act;
    logic [CNT_W-1:0] r_duty_sh [N_CH];

    logic             w_wr_ctrl;
    logic             w_wr_period;
    logic [N_CH-1:0]  w_wr_duty;
    logic             w_wrap;
    logic             w_load;
    ctrl_t            w_ctrl_wd;
    logic [CNT_W-1:0] w_wd;
    logic             w_unused_wdata;

    assign w_wd           = avs_s0_writedata[CNT_W-1:0];
    assign w_ctrl_wd      = ctrl_t'(avs_s0_writedata[1:0]);
    assign w_unused_wdata = ^avs_s0_writedata;

    assign w_wr_ctrl   = avs_s0_write && (avs_s0_address == ADDR_CTRL);
    assign w_wr_period = avs_s0_write && (avs_s0_address == ADDR_PERIOD);

    always_comb begin
        w_wr_duty = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_wr_duty[i] = avs_s0_write && (avs_s0_address == duty_addr(i));
        end
    end

    // Actives track shadows continuously while stopped; while running they
    // move only on a wrap that finds an update already pending.
    assign w_wrap      = r_en && (r_cnt == r_top_act);
    assign w_load      = !r_en || (w_wrap && r_pending);
    assign period_tick = w_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en      <= 1'b0;
            r_pending <= 1'b0;
            r_cnt     <= '0;
            r_top_sh  <= CNT_W'(DEFAULT_TOP);
            r_top_act <= CNT_W'(DEFAULT_TOP);
        end else begin
            if (w_wr_ctrl) begin
                r_en <= w_ctrl_wd.en;
            end
            // A fresh UPD beats the clear on a wrap so it waits a full period.
            if (w_wr_ctrl && !w_ctrl_wd.en) begin
                r_pending <= 1'b0;
            end else if (w_wr_ctrl && w_ctrl_wd.upd) begin
                r_pending <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
            if (w_wr_period) begin
                r_top_sh <= w_wd;
            end
            if (w_load) begin
                r_top_act <= r_top_sh;
            end
            if (!r_en || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_duty_sh[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_wr_duty[i]) begin
                    r_duty_sh[i] <= w_wd;
                end
            end
        end
    end

    always_comb begin
        avs_s0_readdata = '0;
        if (avs_s0_read) begin
            case (avs_s0_address)
                ADDR_CTRL:   avs_s0_readdata[CTRL_EN_BIT] = r_en;
                ADDR_PERIOD: avs_s0_readdata = 32'(r_top_sh);
                ADDR_STATUS: begin
                    avs_s0_readdata[STAT_PEND_BIT] = r_pending;
                    avs_s0_readdata[STAT_RUN_BIT]  = r_en;
                end
                default: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (avs_s0_address == duty_addr(i)) begin
                            avs_s0_readdata = 32'(r_duty_sh[i]);
                        end
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pwm_ch_cmp #(
            .CNT_W(CNT_W)
        ) u_cmp (
            .clk       (clk),
            .reset     (reset),
            .i_load    (w_load),
            .i_en      (r_en),
            .i_duty_sh (r_duty_sh[g]),
            .i_cnt     (r_cnt),
            .o_pwm     (PWM_out[g])
        );
    end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Scoreboard bench for pwm_seq_ctrl: expected per-cycle PWM/tick values are
// queued from a period-level description; register reads are queued and popped.
module tb_pwm_seq_ctrl;
    import pwm_seq_pkg::*;

    localparam int N_CH  = 8;
    localparam int CNT_W = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      address;
    logic            rd;
    logic            wr;
    logic [31:0]     rdata;
    logic [31:0]     wdata;
    logic [N_CH-1:0] pwm;
    logic            tick;

    always #5 clk = ~clk;

    pwm_seq_ctrl #(
        .N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_TOP(255)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .avs_s0_address   (address),
        .avs_s0_read      (rd),
        .avs_s0_write     (wr),
        .avs_s0_readdata  (rdata),
        .avs_s0_writedata (wdata),
        .PWM_out          (pwm),
        .period_tick      (tick)
    );

    typedef struct packed {
        logic [N_CH-1:0] pwm;
        logic            tick;
    } exp_t;

    exp_t            q_exp[$];
    logic [31:0]     q_rd[$];
    int              n_chk = 0;
    int              n_pass = 0;
    int              cur;
    logic [N_CH-1:0] m_next;
    int              duty_m[N_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // One period of top+1 cycles; the output seen in a cycle reflects the
    // previous cycle's count against the duty in force at that time.
    task automatic push_period(input int top);
        for (int p = 0; p <= top; p++) begin
            exp_t e;
            e.pwm  = m_next;
            e.tick = (p == top);
            q_exp.push_back(e);
            for (int i = 0; i < N_CH; i++) m_next[i] = (p < duty_m[i]);
        end
    endtask

    task automatic clk_cyc();
        exp_t e;
        @(negedge clk);
        #1;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            cur++;
            check($sformatf("pwm@%0d", cur), 32'(pwm), 32'(e.pwm));
            check($sformatf("tick@%0d", cur), 32'(tick), 32'(e.tick));
        end
    endtask

    task automatic idle_until(input int target);
        while (cur < target && q_exp.size() > 0) clk_cyc();
    endtask

    task automatic drain();
        while (q_exp.size() > 0) clk_cyc();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        address = a; wdata = d; wr = 1'b1;
        clk_cyc();
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        address = a; rd = 1'b1;
        q_rd.push_back(exp);
        #1;
        check(tag, rdata, q_rd.pop_front());
        clk_cyc();
        rd = 1'b0;
    endtask

    task automatic bus_rw(input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp, input string tag);
        address = a; wdata = d; rd = 1'b1; wr = 1'b1;
        q_rd.push_back(exp);
        #1;
        check(tag, rdata, q_rd.pop_front());
        clk_cyc();
        rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; rd = 1'b0; wr = 1'b0; address = '0; wdata = '0;
        cur = -1; m_next = '0;
        for (int i = 0; i < N_CH; i++) duty_m[i] = 0;

        repeat (3) clk_cyc();
        check("rst_pwm", 32'(pwm), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        reset = 1'b0;
        clk_cyc();
        address = ADDR_PERIOD; #1;
        check("rd_idle_zero", rdata, 32'h0);
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), (a == 1) ? 32'd255 : 32'd0, $sformatf("rst_rd%0d", a));
        end

        // Stopped: program period and duties, then start.
        bus_rw(ADDR_PERIOD, 32'hABCD_0009, 32'd255, "rw_pre_value");
        bus_read(ADDR_PERIOD, 32'd9, "period_trunc");
        bus_write(duty_addr(0), 32'd3);
        bus_write(duty_addr(1), 32'd0);
        bus_write(duty_addr(2), 32'd12);
        bus_read(duty_addr(2), 32'd12, "duty2_rd");
        duty_m[0] = 3; duty_m[1] = 0; duty_m[2] = 12;
        m_next = '0; cur = -1;
        repeat (3) push_period(9);
        bus_write(ADDR_CTRL, 32'h1);
        idle_until(29);

        // Shadow write without UPD leaves the running duty alone.
        cur = -1;
        repeat (2) push_period(9);
        bus_write(duty_addr(0), 32'd7);
        bus_read(ADDR_STATUS, 32'h2, "stat_no_pend");
        bus_read(duty_addr(0), 32'd7, "duty0_shadow");
        idle_until(19);

        // UPD mid-period: pending until the wrap, new duty next period.
        cur = -1;
        push_period(9);
        duty_m[0] = 7;
        repeat (2) push_period(9);
        idle_until(1);
        bus_write(ADDR_CTRL, 32'h3);
        bus_read(ADDR_STATUS, 32'h3, "stat_pend_mid");
        idle_until(9);
        bus_read(ADDR_STATUS, 32'h3, "stat_pend_wrapcyc");
        bus_read(ADDR_STATUS, 32'h2, "stat_applied");
        idle_until(29);

        // UPD during the wrap cycle waits a whole extra period.
        cur = -1;
        repeat (2) push_period(9);
        duty_m[0] = 5;
        repeat (2) push_period(9);
        idle_until(3);
        bus_write(duty_addr(0), 32'd5);
        idle_until(9);
        bus_write(ADDR_CTRL, 32'h3);
        bus_read(ADDR_STATUS, 32'h3, "stat_pend_after_wrap");
        idle_until(19);
        bus_read(ADDR_STATUS, 32'h3, "stat_pend_2nd_wrap");
        bus_read(ADDR_STATUS, 32'h2, "stat_applied_late");
        idle_until(39);

        // Shrink TOP 9 -> 4 mid-period.
        cur = -1;
        push_period(9);
        duty_m[0] = 2;
        repeat (3) push_period(4);
        idle_until(1);
        bus_write(duty_addr(0), 32'd2);
        bus_write(ADDR_PERIOD, 32'd4);
        bus_write(ADDR_CTRL, 32'h3);
        idle_until(24);

        // Reset mid-period while ch0 is high.
        cur = -1;
        push_period(4);
        idle_until(1);
        check("ch0_high_pre_rst", 32'(pwm[0]), 32'h1);
        q_exp.delete();
        reset = 1'b1;
        clk_cyc();
        check("pwm_after_rst", 32'(pwm), 32'h0);
        check("tick_after_rst", 32'(tick), 32'h0);
        reset = 1'b0;
        bus_read(ADDR_CTRL, 32'h0, "rst2_ctrl");
        bus_read(ADDR_PERIOD, 32'd255, "rst2_period");
        bus_read(ADDR_STATUS, 32'h0, "rst2_status");
        bus_read(duty_addr(0), 32'h0, "rst2_duty0");
        bus_read(duty_addr(2), 32'h0, "rst2_duty2");
        m_next = '0; cur = -1;
        for (int i = 0; i < 4; i++) q_exp.push_back('0);
        drain();

        // CTRL write with EN=0, UPD=1 stops and drops the pending update.
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_CTRL, 32'h3);
        bus_read(ADDR_STATUS, 32'h3, "stat_run_pend");
        bus_write(ADDR_CTRL, 32'h2);
        bus_read(ADDR_STATUS, 32'h0, "stat_stop_clr");
        bus_read(ADDR_CTRL, 32'h0, "ctrl_upd_reads0");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
